// File: rtl/agex_muldiv_ctrl_pkg.sv
// Shared types and helpers for the AGEX iterative multiply/divide sequencer.
// Op codes, FSM state encodings, widths and small operand-decode functions.
package agex_muldiv_ctrl_pkg;

  localparam int DBITS   = 32;
  localparam int CNTBITS = 6;

  typedef enum logic [2:0] {
    OP_MUL   = 3'b000,
    OP_MULH  = 3'b001,
    OP_MULHU = 3'b010,
    OP_DIV   = 3'b100,
    OP_DIVU  = 3'b101,
    OP_REM   = 3'b110,
    OP_REMU  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // The reserved encoding 3'b011 folds onto MUL.
  function automatic op_e decode_op(input logic [2:0] raw);
    op_e o;
    if (raw == 3'b011) o = OP_MUL;
    else               o = op_e'(raw);
    return o;
  endfunction

  function automatic logic is_signed_op(input op_e o);
    return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic is_div_op(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
  endfunction

  function automatic logic [DBITS-1:0] magnitude(input logic [DBITS-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/agex_muldiv_ctrl_if.sv
// AGEX <-> muldiv sequencer handshake: request/operands one way, status/result back.
interface agex_muldiv_ctrl_if;
  import agex_muldiv_ctrl_pkg::*;

  logic             start;
  logic [2:0]       op;
  logic [DBITS-1:0] rs1_val;
  logic [DBITS-1:0] rs2_val;
  logic             flush;
  logic             ready;
  logic             busy;
  logic             stall_to_DE;
  logic             done;
  logic [DBITS-1:0] result;

  modport master (
    output start, op, rs1_val, rs2_val, flush,
    input  ready, busy, stall_to_DE, done, result
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, flush,
    output ready, busy, stall_to_DE, done, result
  );

endinterface

// File: rtl/agex_muldiv_ctrl_step.sv
// One radix-2 iteration: shift-add multiply or restoring trial-subtract divide.
// {hi, lo} is the product register (multiply) or {partial remainder, quotient} (divide).
module agex_muldiv_ctrl_step
  import agex_muldiv_ctrl_pkg::*;
(
  input  logic             div_mode,
  input  logic [DBITS-1:0] hi,
  input  logic [DBITS-1:0] lo,
  input  logic [DBITS-1:0] opnd,
  output logic [DBITS-1:0] hi_next,
  output logic [DBITS-1:0] lo_next
);

  logic [DBITS:0]   sum;
  logic [DBITS:0]   rem_shift;
  logic [DBITS-1:0] diff;
  logic             fits;

  // NOTE: every always_comb output gets a value on every path (defaults first)
  // so synthesis never infers a latch.
  always_comb begin
    hi_next   = hi;
    lo_next   = lo;
    sum       = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    rem_shift = {hi, lo[DBITS-1]};
    fits      = rem_shift >= {1'b0, opnd};
    // When the trial subtract fits, the difference is below the divisor, so the low bits suffice.
    diff      = rem_shift[DBITS-1:0] - opnd;
    if (div_mode) begin
      hi_next = fits ? diff : rem_shift[DBITS-1:0];
      lo_next = {lo[DBITS-2:0], fits};
    end else begin
      hi_next = sum[DBITS:1];
      lo_next = {sum[0], lo[DBITS-1:1]};
    end
  end

endmodule

// File: rtl/agex_muldiv_ctrl.sv
// Iterative multiply/divide sequencer for AGEX: fixed 34-cycle schedule
// (accept, 32 iterations, sign fix, done) with a front-end stall while running.
module agex_muldiv_ctrl
  import agex_muldiv_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  agex_muldiv_ctrl_if.slave  bus
);

  state_e             state, state_next;
  logic [CNTBITS-1:0] cnt;
  op_e                op_q;
  logic [DBITS-1:0]   hi, lo, opnd, res_q;
  logic               sign_q, sign_r, div_zero;

  op_e                op_in;
  logic               signed_in;
  logic [DBITS-1:0]   a_mag, b_mag;
  logic               accept, last_iter;
  logic [DBITS-1:0]   hi_step, lo_step;
  logic [2*DBITS-1:0] product;
  logic [DBITS-1:0]   quotient, remainder, fix_result;

  assign op_in     = decode_op(bus.op);
  assign signed_in = is_signed_op(op_in);
  assign a_mag     = magnitude(bus.rs1_val, signed_in & bus.rs1_val[DBITS-1]);
  assign b_mag     = magnitude(bus.rs2_val, signed_in & bus.rs2_val[DBITS-1]);

  assign bus.ready       = (state == ST_IDLE) || (state == ST_DONE);
  assign bus.busy        = (state == ST_CALC) || (state == ST_FIX);
  assign bus.done        = (state == ST_DONE);
  assign accept          = bus.start & bus.ready & ~bus.flush;
  assign bus.stall_to_DE = bus.busy | accept;
  assign bus.result      = bus.done ? res_q : '0;
  assign last_iter       = (cnt == CNTBITS'(DBITS - 1));

  agex_muldiv_ctrl_step u_step (
    .div_mode (is_div_op(op_q)),
    .hi       (hi),
    .lo       (lo),
    .opnd     (opnd),
    .hi_next  (hi_step),
    .lo_next  (lo_step)
  );

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_CALC;
      ST_CALC: if (last_iter) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: state_next = accept ? ST_CALC : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (bus.flush) state_next = ST_IDLE;
  end

  // Sign correction and result selection, registered during FIX.
  always_comb begin
    product = {hi, lo};
    if ((op_q == OP_MULH) && sign_q) product = -product;
    if (div_zero)                           quotient = '1;
    else if ((op_q == OP_DIV) && sign_q)    quotient = -lo;
    else                                    quotient = lo;
    remainder = ((op_q == OP_REM) && sign_r) ? -hi : hi;
    case (op_q)
      OP_MULH, OP_MULHU: fix_result = product[2*DBITS-1:DBITS];
      OP_DIV, OP_DIVU:   fix_result = quotient;
      OP_REM, OP_REMU:   fix_result = remainder;
      default:           fix_result = product[DBITS-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      op_q     <= OP_MUL;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      res_q    <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (accept) begin
        cnt      <= '0;
        op_q     <= op_in;
        hi       <= '0;
        sign_q   <= bus.rs1_val[DBITS-1] ^ bus.rs2_val[DBITS-1];
        sign_r   <= bus.rs1_val[DBITS-1];
        div_zero <= (bus.rs2_val == '0);
        // Divide iterates over the dividend with the divisor fixed; multiply
        // iterates over the multiplier with the multiplicand fixed.
        if (is_div_op(op_in)) begin
          lo   <= a_mag;
          opnd <= b_mag;
        end else begin
          lo   <= b_mag;
          opnd <= a_mag;
        end
      end else if (state == ST_CALC) begin
        hi  <= hi_step;
        lo  <= lo_step;
        cnt <= cnt + CNTBITS'(1);
      end
      if (state == ST_FIX) res_q <= fix_result;
    end
  end

endmodule

// File: tb/tb_agex_muldiv_ctrl.sv
// Self-checking bench for agex_muldiv_ctrl: directed vector table, random ops
// against an arithmetic reference model, and flush/reset/back-to-back sequences.
module tb_agex_muldiv_ctrl;
  import agex_muldiv_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  agex_muldiv_ctrl_if bus ();

  agex_muldiv_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic plus the architectural corner-case rules.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      3'b111: return (b == 32'd0) ? a : 32'(ua % ub);
      default: begin p = ua * ub; return p[31:0]; end
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [5];
    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 255));
    return $urandom;
  endfunction

  // Issue one op from IDLE and check the whole 34-cycle schedule.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int lat;
    bit hold_ok;
    @(negedge clk);
    bus.op      = op;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.start   = 1'b1;
    #1;
    check({name, " stall_at_accept"}, 32'(bus.stall_to_DE), 32'd1);
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.rs1_val = $urandom;
    bus.rs2_val = $urandom;
    lat     = 0;
    hold_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
      if (!bus.stall_to_DE || !bus.busy || bus.result != 32'd0) hold_ok = 1'b0;
    end
    check({name, " latency"}, 32'(lat), 32'd34);
    check({name, " result"}, bus.result, exp);
    check({name, " stall_held"}, 32'(hold_ok), 32'd1);
    check({name, " stall_low_at_done"}, 32'(bus.stall_to_DE), 32'd0);
  endtask

  initial begin
    int n_done, first_done, second_done, done_seen;

    vecs[0]  = '{OP_MUL,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{OP_MULH,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[4]  = '{OP_REM,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[5]  = '{OP_DIVU,  32'd100,        32'd7,         32'd14};
    vecs[6]  = '{OP_REMU,  32'd100,        32'd7,         32'd2};
    vecs[7]  = '{OP_DIVU,  32'h1234,       32'd0,         32'hFFFF_FFFF};
    vecs[8]  = '{OP_REMU,  32'h1234,       32'd0,         32'h1234};
    vecs[9]  = '{OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[10] = '{OP_REM,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    vecs[11] = '{3'b011,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[12] = '{OP_DIV,   32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF};
    vecs[13] = '{OP_REM,   32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};
    vecs[14] = '{OP_MULH,  32'hFFFF_FFFF,  32'd5,         32'hFFFF_FFFF};
    vecs[15] = '{OP_REM,   32'd7,          32'hFFFF_FFFE, 32'd1};

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.op      = 3'b000;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset ready",  32'(bus.ready),       32'd1);
    check("reset busy",   32'(bus.busy),        32'd0);
    check("reset done",   32'(bus.done),        32'd0);
    check("reset stall",  32'(bus.stall_to_DE), 32'd0);
    check("reset result", bus.result,           32'd0);

    for (int i = 0; i < 16; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_op(op, a, b, model(op, a, b), $sformatf("rnd%0d_op%0d", i, op));
    end

    // flush together with start in IDLE must not accept
    @(negedge clk);
    bus.op = OP_MUL; bus.rs1_val = 32'd2; bus.rs2_val = 32'd2;
    bus.start = 1'b1; bus.flush = 1'b1;
    #1;
    check("flush_start stall", 32'(bus.stall_to_DE), 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("flush_start busy",  32'(bus.busy),  32'd0);
    check("flush_start ready", 32'(bus.ready), 32'd1);

    // flush in cycle 10 of a DIV
    @(negedge clk);
    bus.op = OP_DIV; bus.rs1_val = 32'd1000; bus.rs2_val = 32'd3; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush10 busy",  32'(bus.busy),  32'd0);
    check("flush10 ready", 32'(bus.ready), 32'd1);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    check("flush10 no_done", 32'(done_seen), 32'd0);

    // reset in cycle 20 of a MUL
    @(negedge clk);
    bus.op = OP_MUL; bus.rs1_val = 32'd11; bus.rs2_val = 32'd13; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset20 ready",  32'(bus.ready),       32'd1);
    check("reset20 busy",   32'(bus.busy),        32'd0);
    check("reset20 done",   32'(bus.done),        32'd0);
    check("reset20 stall",  32'(bus.stall_to_DE), 32'd0);
    check("reset20 result", bus.result,           32'd0);
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, "after_reset");

    // back-to-back with start held high; operands changed mid-CALC are ignored
    @(negedge clk);
    bus.op = OP_MUL; bus.rs1_val = 32'd3; bus.rs2_val = 32'd5; bus.start = 1'b1;
    @(posedge clk);
    n_done = 0; first_done = 0; second_done = 0;
    for (int k = 1; k <= 72; k++) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        if (n_done == 1) begin
          first_done = k;
          check("b2b result1", bus.result, 32'd15);
          check("b2b stall_in_done", 32'(bus.stall_to_DE), 32'd1);
          bus.rs1_val = 32'd6; bus.rs2_val = 32'd7;
        end else begin
          second_done = k;
          check("b2b result2", bus.result, 32'd42);
          bus.start = 1'b0;
        end
      end else begin
        bus.rs1_val = 32'd9; bus.rs2_val = 32'd9;
      end
    end
    bus.start = 1'b0;
    check("b2b first_cycle",  32'(first_done),  32'd34);
    check("b2b second_cycle", 32'(second_done), 32'd68);
    check("b2b done_count",   32'(n_done),      32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/agex_muldiv_ctrl.md
# agex_muldiv_ctrl

Iterative multiply/divide sequencer for the AGEX stage. It takes over M-extension operations that the single-cycle ALU does not implement in one cycle. It runs a radix-2 shift-add multiplier or a restoring divider over a fixed 34-cycle schedule. While it runs it holds the front of the pipeline with a stall request, and it hands the 32-bit result back to AGEX for the AGEX latch.

## Interface
- DBITS, 32, operand/result width
- CNTBITS, 6, iteration counter width (must hold DBITS)
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- start  input  1  AGEX holds a valid muldiv instruction; sampled only when ready=1
- op  input  3  000 MUL, 001 MULH, 010 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU (011 reserved, treated as MUL)
- rs1_val  input  DBITS  operand A (dividend / multiplicand), captured on accept
- rs2_val  input  DBITS  operand B (divisor / multiplier), captured on accept
- flush  input  1  branch-mispredict squash from AGEX; cancels any operation
- ready  output  1  high in IDLE and DONE; start accepted when start&ready&~flush
- busy  output  1  high in CALC and FIX
- stall_to_DE  output  1  combinational: busy | (start & ready & ~flush); held until result delivered
- done  output  1  one-cycle pulse in DONE
- result  output  DBITS  valid only while done=1; 0 otherwise

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: on accept, latch op and operands. Latch magnitudes |A| and |B| for signed ops (MULH, DIV, REM) and raw values otherwise. Record sign_q = A[31]^B[31] and sign_r = A[31]. Set cnt=0 and go to CALC.
- CALC, multiply: 64-bit product register. Each cycle, if multiplier LSB=1 add multiplicand into the upper half, then shift right 1. 32 cycles, cnt 0..31. After cnt==31 go to FIX.
- CALC, divide: restoring divide with a 33-bit partial remainder. Each cycle shift in the next dividend bit, trial-subtract the divisor, and set the quotient bit on non-negative. 32 cycles, then FIX.
- FIX: apply sign correction.
  - MULH: negate the 64-bit product when sign_q=1.
  - DIV: negate the quotient when sign_q=1.
  - REM: negate the remainder when sign_r=1.
  - Select the result: MUL gives low 32 bits; MULH/MULHU give high 32 bits; DIV/DIVU give quotient; REM/REMU give remainder. Go to DONE.
- Divide by zero (B==0, checked at accept): quotient = 0xFFFFFFFF and remainder = A, for both signed and unsigned. The schedule is unchanged (still 34 cycles).
- Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- DONE: done=1 and result is driven. If start is accepted, go to CALC (back-to-back); otherwise go to IDLE.
- start while busy: ignored, and the captured operands are unchanged.
- flush in any state: next state IDLE and done is not asserted. flush wins over a simultaneous start.
- reset: same as flush. All registers are cleared.

## Timing
- Accept edge = cycle 0. CALC occupies cycles 1–32, FIX is cycle 33, DONE (done=1) is cycle 34.
- Latency from accept to done is 34 cycles. Throughput is one op per 34 cycles when back-to-back starts land in DONE.
- stall_to_DE is high from the accept cycle through cycle 33 and low in cycle 34, so AGEX latches result on the cycle-34 edge.
- Reset values: ready=1, busy=0, done=0, stall_to_DE=0 (with start=0), result=0, state=IDLE, cnt=0.
- flush asserted in cycle k: state is IDLE in cycle k+1, and busy=0 and ready=1 in k+1.

## Structure
- define.vh gains the MULDIV op codes (3 bits), the state encodings (2 bits) and CNTBITS. DBITS is reused.
- One combinational sub-module, muldiv_step, computes a single radix-2 iteration (add-shift or trial-subtract) from the current registers and op class. agex_muldiv_ctrl keeps the FSM, counter, operand and sign registers, and FIX logic.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) -> done in cycle 34, result 0xFFFFFFEB; stall_to_DE high cycles 0–33.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF; REMU 0x1234 / 0 -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, all at cycle 34.
- Flush and reset:
  - flush in cycle 10 of a DIV -> IDLE at cycle 11 with done never pulsed.
  - flush together with start in IDLE -> no accept.
  - reset at cycle 20 -> all outputs at reset values next cycle.
- Back-to-back: start held high, MUL 3×5 then MUL 6×7 -> done at cycles 34 and 68 with results 15 and 42. start asserted during CALC is ignored (operands unchanged).
